// File: rtl/dart_disp_pkg.sv
// Shared constants for the dart score display: conversion FSM encodings,
// 7-segment patterns, digit counts and the double-dabble step.
package dart_disp_pkg;

    localparam int NUM_DIGITS        = 6;
    localparam int DIGITS_PER_PLAYER = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    // {g,f,e,d,c,b,a}; codes 10..15 never come out of the converter and stay dark
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    // One double-dabble iteration: correct each nibble >= 5, then shift in bit_in.
    function automatic logic [11:0] dabble_step(input logic [11:0] acc, input logic bit_in);
        logic [11:0] adj;
        // NOTE: blocking assignments are correct here; the function is pure
        // combinational arithmetic evaluated in order, not clocked state.
        adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        end
        return {adj[10:0], bit_in};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial 9-bit double-dabble converter: start_i loads bin_i, nine shift cycles follow.
// done_o marks the final shift; bcd_o holds the finished result from the next cycle on.
module bin2bcd_seq
    import dart_disp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [8:0]  bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    logic [8:0]  r_sr;
    logic [11:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_busy;

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start_i && !r_busy) begin
            r_sr   <= bin_i;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= dabble_step(r_acc, r_sr[8]);
            r_sr  <= {r_sr[7:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd8) r_busy <= 1'b0;
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_busy && (r_cnt == 4'd8);
    assign bcd_o  = r_acc;

endmodule

// File: rtl/dart_score_display.sv
// Six-digit multiplexed score display for two dart players with winner blink.
// Define DART_DISP_LZB_EN to blank leading zeros on the tens and hundreds digits.
module dart_score_display
    import dart_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] player_1_pt_i,
    input  logic [8:0] player_2_pt_i,
    input  logic       player_1_win_i,
    input  logic       player_2_win_i,
    input  logic       game_set_i,
    output logic [6:0] seg_o,
    output logic [5:0] an_o,
    output logic       bcd_valid_o
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [1:0]  r_state;
    logic        r_sel;          // 0: player 1 is being converted
    logic [11:0] r_bcd_p1, r_bcd_p2;
    logic        r_bcd_valid;

    logic        w_start, w_busy, w_done;
    logic [8:0]  w_bin;
    logic [11:0] w_bcd;

    assign w_start = (r_state == ST_LOAD);
    assign w_bin   = r_sel ? player_2_pt_i : player_1_pt_i;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_start),
        .bin_i   (w_bin),
        .busy_o  (w_busy),
        .done_o  (w_done),
        .bcd_o   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_bcd_p1    <= '0;
            r_bcd_p2    <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_LOAD;
                ST_LOAD:  if (!w_busy) r_state <= ST_SHIFT;
                ST_SHIFT: if (w_done) r_state <= ST_STORE;
                ST_STORE: begin
                    if (r_sel) begin
                        r_bcd_p2    <= w_bcd;
                        r_bcd_valid <= 1'b1;
                    end else begin
                        r_bcd_p1 <= w_bcd;
                    end
                    r_sel   <= ~r_sel;
                    r_state <= ST_LOAD;
                end
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [2:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic [1:0]         r_win;
    logic               r_set_seen;
    logic [6:0]         r_seg;
    logic [5:0]         r_an;

    logic        w_is_p2, w_blank;
    logic [11:0] w_bcd_sel;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;

    always_comb begin
        // NOTE: every variable gets a value before any conditional logic, so
        // no path leaves one unassigned and no latch is inferred.
        w_is_p2   = (r_idx >= 3'(DIGITS_PER_PLAYER));
        w_bcd_sel = w_is_p2 ? r_bcd_p2 : r_bcd_p1;
        w_nib     = w_bcd_sel[11:8];
        w_blank   = 1'b0;
        case (r_idx)
            3'd0, 3'd3: w_nib = w_bcd_sel[3:0];
            3'd1, 3'd4: w_nib = w_bcd_sel[7:4];
            default:    w_nib = w_bcd_sel[11:8];
        endcase
`ifdef DART_DISP_LZB_EN
        if ((r_idx == 3'd2 || r_idx == 3'd5) && w_bcd_sel[11:8] == 4'd0) w_blank = 1'b1;
        if ((r_idx == 3'd1 || r_idx == 3'd4) && w_bcd_sel[11:4] == 8'd0) w_blank = 1'b1;
`else
`endif
        if (!r_blink_on && (w_is_p2 ? r_win[1] : r_win[0])) w_blank = 1'b1;
        w_seg = w_blank ? 7'd0 : SEG_LUT[w_nib];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_win       <= 2'b00;
            r_set_seen  <= 1'b0;
            r_seg       <= '0;
            r_an        <= 6'b000001;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end

            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end

            // Only the first game-over pulse after reset decides the winner.
            if (game_set_i && !r_set_seen) begin
                r_win      <= {player_2_win_i, player_1_win_i};
                r_set_seen <= 1'b1;
            end

            r_seg <= w_seg;
            r_an  <= 6'b000001 << r_idx;
        end
    end

    assign seg_o       = r_seg;
    assign an_o        = r_an;
    assign bcd_valid_o = r_bcd_valid;

endmodule

// File: doc/dart_score_display.md
Name: dart_score_display

Overview:
- Downstream consumer of the dart scoring machine. Takes both players' 9-bit scores and the game-set/win flags.
- Converts each score to 3 BCD digits with a serial double-dabble converter.
- Drives a 6-digit multiplexed 7-segment display: player 1 on digits 0-2, player 2 on digits 3-5.
- After game set, the winner's digits blink.

Parameters:
- SCAN_DIV, 16, clock cycles each digit stays selected (>=2).
- BLINK_DIV, 64, clock cycles per blink half-period (>=2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- player_1_pt_i  input  9  player 1 score, 0..511
- player_2_pt_i  input  9  player 2 score, 0..511
- player_1_win_i  input  1  player 1 score is 0
- player_2_win_i  input  1  player 2 score is 0
- game_set_i  input  1  one-cycle game-over pulse
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-high
- an_o  output  6  one-hot digit select, active-high; bit k = digit k
- bcd_valid_o  output  1  high once both players have completed a conversion

Behaviour:
- One clock, clk. Reset is synchronous, active-high, port name reset.
- Reset values:
  - seg_o=0, an_o=6'b000001, bcd_valid_o=0.
  - bcd_p1 and bcd_p2 = 12'h000; scan index 0; scan and blink counters 0; blink phase on; winner latch 2'b00.
- Conversion FSM, states IDLE, LOAD, SHIFT, STORE:
  - Leave reset in IDLE; go to LOAD on the next cycle.
  - LOAD: latch the selected player's score (player 1 first, then alternate) into a 9-bit shift register; clear the 12-bit BCD accumulator.
  - SHIFT: 9 cycles. Each cycle, add 3 to any BCD nibble >=5, then shift left 1, bringing in the shift-register MSB.
  - STORE: write the accumulator into bcd_p1 or bcd_p2; toggle the selected player; go to LOAD.
  - One conversion takes 11 cycles. A score change appears in BCD within 22 cycles.
  - The input is sampled only in LOAD. Changes during SHIFT are picked up on that player's next pass.
- bcd_valid_o: set in the cycle after the first player-2 STORE; cleared only by reset.
- Scan:
  - Divider counts 0..SCAN_DIV-1. At terminal count, index advances; 5 wraps to 0.
  - seg_o and an_o are registered, one cycle behind the index.
  - Digit index 0/1/2 = player 1 units/tens/hundreds; 3/4/5 = player 2 units/tens/hundreds.
- Segment decode: 0..9 use standard patterns (0=7'h3F, 1=7'h06, 5=7'h6D, 7=7'h07). Nibbles 10..15 give 0; they cannot occur.
- Winner latch:
  - Captures {player_2_win_i, player_1_win_i} on the game_set_i cycle. Both bits may be set.
  - Held until reset; later game_set_i pulses are ignored.
- Blink:
  - Counter runs continuously; phase toggles every BLINK_DIV cycles.
  - When phase is off and the digit belongs to a latched winner, seg_o=0 while an_o still advances.
- Reset mid-operation: conversion aborts, BCD registers clear, the FSM restarts with player 1.

Optional Feature:
- DART_DISP_LZB_EN defined: leading-zero blanking.
  - Hundreds digit shows seg 0 when its nibble is 0.
  - Tens digit shows seg 0 when hundreds and tens are both 0.
  - Units digit is always shown.
- Undefined: all three digits always decoded, e.g. 7 shows "007".

Decomposition:
- Package dart_disp_pkg holds:
  - conversion FSM state encodings (2-bit);
  - the 16-entry 7-segment pattern constant array;
  - NUM_DIGITS=6 and DIGITS_PER_PLAYER=3.
- Sub-module bin2bcd_seq:
  - 9-bit serial double-dabble converter.
  - Ports: start_i, bin_i[8:0], busy_o, done_o (1-cycle pulse), bcd_o[11:0].
  - The top level owns player select, STORE, scan and blink.

Test Plan:
- Reset held 3 cycles, then released: an_o=6'b000001, seg_o=0. bcd_valid_o rises at cycle 23 after release.
- SCAN_DIV=4, pt1=501, pt2=437, wait 25 cycles, then scan:
  - digit0 = 7'h06, digit1 = 7'h3F, digit2 = 7'h6D (player 1 shows 501);
  - digits 3-5 read 7, 3, 4.
- DART_DISP_LZB_EN defined, pt1=7: digit0 = 7'h07, digits 1-2 = 0. Undefined: digits 1-2 = 7'h3F.
- pt1 changes 501 -> 481 on the 3rd SHIFT cycle: bcd_p1 stays 12'h501 until the next player-1 STORE, then becomes 12'h481.
- pt2=0, player_2_win_i=1, game_set_i pulse, BLINK_DIV=8:
  - digits 3-5 blank for alternating 8-cycle windows;
  - digit 3 otherwise shows 7'h3F (zero);
  - digits 0-2 stay steady;
  - a second game_set_i with player_1_win_i=1 changes nothing.
- reset asserted during SHIFT with pt1=301: next cycle BCD = 0, bcd_valid_o = 0. After release, the first STORE writes bcd_p1 = 12'h301.
